// File: rtl/xb_stream_pkg.sv
// Shared types and defaults for the Xillybus read-stream source.
// Build option: XB_READ_STREAM_DROP_CNT_EN adds the drop_cnt output to the top.
package xb_stream_pkg;

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        EOF    = 2'd3
    } xb_state_e;

    localparam int XB_DATA_W       = 32;
    localparam int XB_DEPTH_LOG2   = 4;
    localparam int XB_AFULL_MARGIN = 2;

endpackage

// File: rtl/xb_sync_fifo.sv
// Single-clock FIFO with a registered (non-FWFT) read port and a synchronous flush.
module xb_sync_fifo
    import xb_stream_pkg::*;
#(
    parameter int DEPTH_LOG2   = XB_DEPTH_LOG2,
    parameter int DATA_W       = XB_DATA_W,
    parameter int AFULL_MARGIN = XB_AFULL_MARGIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_afull,
    output logic              o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] MARGIN_C = (DEPTH_LOG2+1)'(AFULL_MARGIN);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DATA_W-1:0]     r_rd_data;
    logic [DEPTH_LOG2:0]   w_free;
    logic                  w_wr;
    logic                  w_rd;

    // Flags come straight from the registered count, so a same-cycle read never frees a slot.
    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    assign w_free    = DEPTH_C - r_count;
    assign o_afull   = (w_free <= MARGIN_C);
    assign o_rd_data = r_rd_data;

    assign w_wr = i_wr_en && !o_full  && !i_flush;
    assign w_rd = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_data <= r_mem[r_rptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/xb_read_stream_src.sv
// Producer-side source for one Xillybus read pipe: open/close gating, drain and EOF.
// Build option: XB_READ_STREAM_DROP_CNT_EN adds a saturating drop_cnt output.
module xb_read_stream_src
    import xb_stream_pkg::*;
#(
    parameter int DEPTH_LOG2   = XB_DEPTH_LOG2,
    parameter int DATA_W       = XB_DATA_W,
    parameter int AFULL_MARGIN = XB_AFULL_MARGIN
) (
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              smp_last,
    output logic              smp_full,
    output logic              smp_afull,
    output logic              smp_drop,
`ifdef XB_READ_STREAM_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    input  logic              xb_open,
    input  logic              xb_rden,
    output logic [DATA_W-1:0] xb_data,
    output logic              xb_empty,
    output logic              xb_eof
);

    xb_state_e r_state;
    xb_state_e w_state_nxt;
    logic      r_drop;
    logic      w_live;
    logic      w_fifo_empty;
    logic      w_rd;
    logic      w_wr;
    logic      w_flush;

    assign w_live   = (r_state == STREAM) || (r_state == DRAIN);
    assign xb_empty = w_fifo_empty || !w_live;
    assign xb_eof   = (r_state == EOF);
    assign w_rd     = xb_rden && !xb_empty;
    assign w_wr     = smp_valid && !smp_full && (r_state == STREAM);
    // CLOSED keeps the FIFO flushed, so a close discards everything one cycle after open falls.
    assign w_flush  = (r_state == CLOSED);
    assign smp_drop = r_drop;

    xb_sync_fifo #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .DATA_W       (DATA_W),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_fifo (
        .clk       (bus_clk),
        .rst       (bus_rst),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr),
        .i_wr_data (smp_data),
        .i_rd_en   (w_rd),
        .o_rd_data (xb_data),
        .o_full    (smp_full),
        .o_afull   (smp_afull),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_state <= CLOSED;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= smp_valid && !w_wr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLOSED: if (xb_open) w_state_nxt = STREAM;
            STREAM: begin
                if (!xb_open)                w_state_nxt = CLOSED;
                else if (w_wr && smp_last)   w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!xb_open)                w_state_nxt = CLOSED;
                else if (w_fifo_empty && !w_rd) w_state_nxt = EOF;
            end
            EOF:    if (!xb_open) w_state_nxt = CLOSED;
            default: w_state_nxt = CLOSED;
        endcase
    end

`ifdef XB_READ_STREAM_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_drop_cnt <= '0;
        end else if ((r_state == CLOSED) && xb_open) begin
            r_drop_cnt <= '0;
        end else if (r_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_xb_read_stream_src.sv
// Self-checking bench for xb_read_stream_src against a queue-based reference model.
module tb_xb_read_stream_src;

    localparam int DEPTH = 16;
    localparam int P_CLOSED = 0, P_STREAM = 1, P_DRAIN = 2, P_EOF = 3;

    logic        bus_clk = 1'b0;
    logic        bus_rst;
    logic        smp_valid, smp_last, xb_open, xb_rden;
    logic [31:0] smp_data;
    logic        smp_full, smp_afull, smp_drop, xb_empty, xb_eof;
    logic [31:0] xb_data;
`ifdef XB_READ_STREAM_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    xb_read_stream_src dut (
        .bus_clk   (bus_clk),
        .bus_rst   (bus_rst),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .smp_last  (smp_last),
        .smp_full  (smp_full),
        .smp_afull (smp_afull),
        .smp_drop  (smp_drop),
`ifdef XB_READ_STREAM_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .xb_open   (xb_open),
        .xb_rden   (xb_rden),
        .xb_data   (xb_data),
        .xb_empty  (xb_empty),
        .xb_eof    (xb_eof)
    );

    always #5 bus_clk = ~bus_clk;

    // Reference model: stored words, session phase, last delivered word, drop bookkeeping.
    logic [31:0] q[$];
    int          ph;
    logic [31:0] m_data;
    bit          m_drop;
    int          m_cnt;
    int          n_pass = 0;
    int          n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic mdl_reset();
        q.delete();
        ph     = P_CLOSED;
        m_data = '0;
        m_drop = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic chk_all(input string tag);
        bit live;
        live = (ph == P_STREAM) || (ph == P_DRAIN);
        chk({tag, "/data"},  xb_data, m_data);
        chk({tag, "/empty"}, 32'(xb_empty),  32'(!live || q.size() == 0));
        chk({tag, "/eof"},   32'(xb_eof),    32'(ph == P_EOF));
        chk({tag, "/full"},  32'(smp_full),  32'(q.size() == DEPTH));
        chk({tag, "/afull"}, 32'(smp_afull), 32'((DEPTH - q.size()) <= 2));
        chk({tag, "/drop"},  32'(smp_drop),  32'(m_drop));
`ifdef XB_READ_STREAM_DROP_CNT_EN
        chk({tag, "/dcnt"},  32'(drop_cnt),  32'(m_cnt));
`endif
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next fall.
    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic l, input logic rd, input logic op);
        int pre_sz;
        bit live, emp, acc, rdok;
        smp_valid = v; smp_data = d; smp_last = l; xb_rden = rd; xb_open = op;
        pre_sz = q.size();
        live   = (ph == P_STREAM) || (ph == P_DRAIN);
        emp    = !live || pre_sz == 0;
        acc    = v && pre_sz < DEPTH && ph == P_STREAM;
        rdok   = rd && !emp;
        @(posedge bus_clk);
        if (ph == P_CLOSED && op)            m_cnt = 0;
        else if (m_drop && m_cnt != 16'hFFFF) m_cnt++;
        m_drop = v && !acc;
        if (rdok) m_data = q.pop_front();
        if (acc)  q.push_back(d);
        case (ph)
            P_CLOSED: begin q.delete(); if (op) ph = P_STREAM; end
            P_STREAM: if (!op) ph = P_CLOSED; else if (acc && l) ph = P_DRAIN;
            P_DRAIN:  if (!op) ph = P_CLOSED; else if (pre_sz == 0) ph = P_EOF;
            default:  if (!op) ph = P_CLOSED;
        endcase
        @(negedge bus_clk);
        chk_all(tag);
    endtask

    task automatic idle(input string tag, input int n, input logic op);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, 1'b0, 1'b0, op);
    endtask

    initial begin
        smp_valid = 0; smp_data = 0; smp_last = 0; xb_rden = 0; xb_open = 0;
        bus_rst = 1'b1;
        mdl_reset();
        #3;
        chk_all("reset");
        @(negedge bus_clk);
        @(negedge bus_clk);
        bus_rst = 1'b0;
        idle("closed_idle", 2, 1'b0);

        // Basic write/read ordering
        step("open", 0, 0, 0, 0, 1);
        step("w11", 1, 32'h11, 0, 0, 1);
        step("w22", 1, 32'h22, 0, 0, 1);
        step("w33", 1, 32'h33, 0, 0, 1);
        step("r1", 0, 0, 0, 1, 1);
        chk("tp1_r1", xb_data, 32'h11);
        step("r2", 0, 0, 0, 1, 1);
        chk("tp1_r2", xb_data, 32'h22);
        step("r3", 0, 0, 0, 1, 1);
        chk("tp1_r3", xb_data, 32'h33);
        chk("tp1_empty", 32'(xb_empty), 32'd1);
        step("r_on_empty", 0, 0, 0, 1, 1);

        // Fill to full, overflow drop, then drain
        for (int i = 0; i < 16; i++) step("fill", 1, 32'h200 + 32'(i), 0, 0, 1);
        chk("tp2_full", 32'(smp_full), 32'd1);
        step("overflow", 1, 32'hDEAD, 0, 0, 1);
        chk("tp2_drop", 32'(smp_drop), 32'd1);
        step("full_rw", 1, 32'hBEEF, 0, 1, 1);
        for (int i = 0; i < 15; i++) step("drain_full", 0, 0, 0, 1, 1);
        chk("tp2_last", xb_data, 32'h20F);

        // Concurrent read/write at count 5 across the pointer wrap
        for (int i = 0; i < 5; i++) step("pre5", 1, 32'h300 + 32'(i), 0, 0, 1);
        for (int i = 0; i < 10; i++) step("rw5", 1, 32'h400 + 32'(i), 0, 1, 1);
        chk("tp3_cnt5", 32'(q.size()), 32'd5);
        for (int i = 0; i < 5; i++) step("post5", 0, 0, 0, 1, 1);
        chk("tp3_tail", xb_data, 32'h409);

        // End-of-stream path
        step("wA", 1, 32'hA, 0, 0, 1);
        step("wB_last", 1, 32'hB, 1, 0, 1);
        step("drain_wr", 1, 32'hC, 0, 0, 1);
        step("rA", 0, 0, 0, 1, 1);
        step("rB", 0, 0, 0, 1, 1);
        chk("tp4_noeof_yet", 32'(xb_eof), 32'd0);
        step("to_eof", 0, 0, 0, 0, 1);
        chk("tp4_eof", 32'(xb_eof), 32'd1);
        step("eof_wr", 1, 32'hD, 0, 1, 1);
        chk("tp4_eof_drop", 32'(smp_drop), 32'd1);
        step("close", 0, 0, 0, 0, 0);
        chk("tp4_eof_clr", 32'(xb_eof), 32'd0);
        idle("closed2", 1, 1'b0);

        // Close mid-stream discards content
        step("reopen", 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("w4", 1, 32'h500 + 32'(i), 0, 0, 1);
        step("close_mid", 1, 32'h5FF, 0, 1, 0);
        step("reopen2", 0, 0, 0, 0, 1);
        chk("tp5_empty", 32'(xb_empty), 32'd1);
        step("read_gone", 0, 0, 0, 1, 1);
`ifdef XB_READ_STREAM_DROP_CNT_EN
        chk("tp5_dcnt", 32'(drop_cnt), 32'd0);
`endif

        // Randomized traffic including occasional last and close
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) != 0));

        // Async reset while half full in DRAIN
        idle("pre_rst_close", 1, 1'b0);
        step("pre_rst_open", 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step("half", 1, 32'h600 + 32'(i), 0, 0, 1);
        step("half_last", 1, 32'h607, 1, 0, 1);
        step("half_r", 0, 0, 0, 1, 1);
        chk("tp6_in_drain", 32'(ph), 32'(P_DRAIN));
        #1 bus_rst = 1'b1;
        #1;
        mdl_reset();
        chk_all("async_rst");
        chk("tp6_data0", xb_data, 32'h0);
        @(negedge bus_clk);
        bus_rst = 1'b0;
        idle("post_rst", 2, 1'b0);
        step("post_rst_open", 0, 0, 0, 0, 1);
        step("post_rst_w", 1, 32'h77, 0, 0, 1);
        step("post_rst_r", 0, 0, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
